// File: rtl/wb_regfile_if.sv
// Writeback-stage bundle in, decode read ports and writeback tuple out.
interface wb_regfile_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 64
);
    localparam int unsigned AW = 5;

    logic [DATA_W-1:0] alu_result_w;
    logic [DATA_W-1:0] pc_plus4_w;
    logic [DATA_W-1:0] read_data_w;
    logic [31:0]       instr_w;
    logic [AW-1:0]     rs1_addr;
    logic [AW-1:0]     rs2_addr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              wb_en;
    logic [AW-1:0]     wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [CNT_W-1:0]  instret;

    // Pipeline / decode side
    modport master (
        output alu_result_w, pc_plus4_w, read_data_w, instr_w, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wb_en, wb_rd, wb_data, instret
    );

    // Register file side
    modport slave (
        input  alu_result_w, pc_plus4_w, read_data_w, instr_w, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wb_en, wb_rd, wb_data, instret
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: decode, load alignment, 32x32 register file with
// write-first bypass on both read ports, and retired-instruction counter.
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_regfile_if.slave bus
);
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [6:0]        opcode;
    logic [AW-1:0]     rd;
    logic [2:0]        funct3;
    logic [1:0]        off;

    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [DATA_W-1:0] load_val;
    logic              wr_op;
    logic [DATA_W-1:0] sel_val;
    logic              wb_en_c;
    logic [DATA_W-1:0] wb_data_c;
    logic [DATA_W-1:0] rs1_c;
    logic [DATA_W-1:0] rs2_c;

    logic [DATA_W-1:0] regs_q [1:NREG-1];
    logic [CNT_W-1:0]  instret_q;
    logic [CNT_W-1:0]  instret_d;

    assign opcode = bus.instr_w[6:0];
    assign rd     = bus.instr_w[11:7];
    assign funct3 = bus.instr_w[14:12];
    assign off    = bus.alu_result_w[1:0];

    // Pick the addressed byte/halfword out of the little-endian memory word
    always_comb begin
        byte_v = bus.read_data_w[7:0];
        half_v = bus.read_data_w[15:0];
        case (off)
            2'd0:    byte_v = bus.read_data_w[7:0];
            2'd1:    byte_v = bus.read_data_w[15:8];
            2'd2:    byte_v = bus.read_data_w[23:16];
            default: byte_v = bus.read_data_w[31:24];
        endcase
        if (off[1]) begin
            half_v = bus.read_data_w[31:16];
        end
    end

    // Extend the selected lane according to the load width; misaligned
    // halfwords simply drop off[0], and unknown widths return the full word
    always_comb begin
        load_val = bus.read_data_w;
        case (funct3)
            F3_LB:   load_val = {{(DATA_W-8){byte_v[7]}}, byte_v};
            F3_LBU:  load_val = {{(DATA_W-8){1'b0}}, byte_v};
            F3_LH:   load_val = {{(DATA_W-16){half_v[15]}}, half_v};
            F3_LHU:  load_val = {{(DATA_W-16){1'b0}}, half_v};
            default: load_val = bus.read_data_w;
        endcase
    end

    // Writeback source select; non-writing opcodes (incl. bubble) produce 0
    always_comb begin
        wr_op   = 1'b0;
        sel_val = '0;
        case (opcode)
            OPC_LOAD: begin
                wr_op   = 1'b1;
                sel_val = load_val;
            end
            OPC_JAL, OPC_JALR: begin
                wr_op   = 1'b1;
                sel_val = bus.pc_plus4_w;
            end
            OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: begin
                wr_op   = 1'b1;
                sel_val = bus.alu_result_w;
            end
            default: begin
                wr_op   = 1'b0;
                sel_val = '0;
            end
        endcase
        wb_en_c   = wr_op && (rd != '0);
        wb_data_c = wb_en_c ? sel_val : '0;
    end

    // Register array; x0 has no storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en_c) begin
            for (int i = 1; i < NREG; i++) begin
                if (rd == AW'(i)) begin
                    regs_q[i] <= wb_data_c;
                end
            end
        end
    end

    // Read ports: x0 and reset force 0, same-cycle write wins over storage
    always_comb begin
        rs1_c = '0;
        rs2_c = '0;
        for (int i = 1; i < NREG; i++) begin
            if (bus.rs1_addr == AW'(i)) begin
                rs1_c = regs_q[i];
            end
            if (bus.rs2_addr == AW'(i)) begin
                rs2_c = regs_q[i];
            end
        end
        if (wb_en_c && (bus.rs1_addr == rd)) begin
            rs1_c = wb_data_c;
        end
        if (wb_en_c && (bus.rs2_addr == rd)) begin
            rs2_c = wb_data_c;
        end
        if (!rst_n || (bus.rs1_addr == '0)) begin
            rs1_c = '0;
        end
        if (!rst_n || (bus.rs2_addr == '0)) begin
            rs2_c = '0;
        end
    end

    // Any non-bubble instruction retires, writing or not; wraps silently
    always_comb begin
        instret_d = instret_q;
        if (bus.instr_w != 32'h0) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    // Retire counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign bus.rs1_data = rs1_c;
    assign bus.rs2_data = rs2_c;
    assign bus.wb_en    = wb_en_c;
    assign bus.wb_rd    = rd;
    assign bus.wb_data  = wb_data_c;
    assign bus.instret  = instret_q;

endmodule
